// File: rtl/stopwatch_control_fsm.sv
// Stopwatch sequencing controller: turns debounced button levels into the
// timer/counter state code, a one-cycle counter clear, a lap display freeze
// and a running flag. Outputs are registered from the next-state value, so
// they change at the same edge as the FSM and carry no input-to-output path.
module stopwatch_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_startstop,
    input  logic       btn_lap,
    input  logic       btn_reset,
    input  logic       at_max,
    output logic [3:0] state,
    output logic       clear,
    output logic       display_hold,
    output logic       running
);

    // state    | meaning
    // S_IDLE   | counters zeroed, waiting for start
    // S_CLEAR  | single cycle that zeroes the counters
    // S_STOP   | counting halted, time shown live
    // S_RUN    | counting, time shown live
    // S_LAPRUN | counting, display frozen on lap time
    // S_LAPSTP | halted, display frozen on lap time
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STOP   = 3'd2,
        S_RUN    = 3'd3,
        S_LAPRUN = 3'd4,
        S_LAPSTP = 3'd5
    } fsm_t;

    fsm_t       fsm_q;
    fsm_t       fsm_d;
    logic [2:0] btn_prev_q;
    logic       ss_press;
    logic       lap_press;
    logic       rst_press;

    // Rising-edge press detect; prev registers reset high so a button held
    // through reset must be released before it counts as a press.
    always_comb begin
        ss_press  = btn_startstop & ~btn_prev_q[2];
        lap_press = btn_lap       & ~btn_prev_q[1];
        rst_press = btn_reset     & ~btn_prev_q[0];
    end

    // Next-state selection; within each state the first matching branch wins,
    // and presses not acted on are dropped rather than remembered.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (ss_press) fsm_d = S_RUN;
            end
            S_CLEAR: begin
                fsm_d = S_IDLE;
            end
            S_RUN: begin
                if (at_max)         fsm_d = S_STOP;
                else if (ss_press)  fsm_d = S_STOP;
                else if (lap_press) fsm_d = S_LAPRUN;
            end
            S_LAPRUN: begin
                if (at_max || ss_press) fsm_d = S_LAPSTP;
                else if (lap_press)     fsm_d = S_RUN;
            end
            S_STOP: begin
                if (rst_press)                fsm_d = S_CLEAR;
                else if (ss_press && !at_max) fsm_d = S_RUN;
            end
            S_LAPSTP: begin
                if (rst_press) begin
                    fsm_d = S_CLEAR;
                end else if (ss_press) begin
                    // A blocked start still consumes the cycle; lap is dropped.
                    if (!at_max) fsm_d = S_LAPRUN;
                end else if (lap_press) begin
                    fsm_d = S_STOP;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State, button history and registered output decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            btn_prev_q   <= 3'b111;
            state        <= 4'd0;
            clear        <= 1'b0;
            display_hold <= 1'b0;
            running      <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            btn_prev_q   <= {btn_startstop, btn_lap, btn_reset};
            clear        <= (fsm_d == S_CLEAR);
            display_hold <= (fsm_d == S_LAPRUN) || (fsm_d == S_LAPSTP);
            running      <= (fsm_d == S_RUN) || (fsm_d == S_LAPRUN);
            case (fsm_d)
                S_CLEAR:            state <= 4'd1;
                S_STOP, S_LAPSTP:   state <= 4'd2;
                S_RUN, S_LAPRUN:    state <= 4'd3;
                default:            state <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_control_fsm.sv
// Bench for stopwatch_control_fsm: a behavioural model predicts the outputs
// for every driven cycle, the prediction is queued, and it is popped and
// compared once the DUT has taken the edge. Directed sequences add fixed
// expectations on top of the model.
module tb_stopwatch_control_fsm;

    logic       clk;
    logic       rst_n;
    logic       btn_startstop;
    logic       btn_lap;
    logic       btn_reset;
    logic       at_max;
    logic [3:0] state;
    logic       clear;
    logic       display_hold;
    logic       running;

    typedef struct packed {
        logic [3:0] st;
        logic       clr;
        logic       hold;
        logic       run;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_tot;
    int   m_st;          // 0 idle,1 clear,2 stopped,3 run,4 lap_run,5 lap_stop
    logic [2:0] m_prev;
    int   clear_cycles;

    stopwatch_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_startstop (btn_startstop),
        .btn_lap       (btn_lap),
        .btn_reset     (btn_reset),
        .at_max        (at_max),
        .state         (state),
        .clear         (clear),
        .display_hold  (display_hold),
        .running       (running)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model of one clock edge.
    task automatic model_step(input logic rn, input logic ss, input logic lp,
                              input logic rs, input logic am);
        logic ps, pl, pr;
        if (!rn) begin
            m_st   = 0;
            m_prev = 3'b111;
            return;
        end
        ps = ss & ~m_prev[2];
        pl = lp & ~m_prev[1];
        pr = rs & ~m_prev[0];
        m_prev = {ss, lp, rs};
        if (m_st == 0) begin
            if (ps) m_st = 3;
        end else if (m_st == 1) begin
            m_st = 0;
        end else if (m_st == 3) begin
            if (am || ps) m_st = 2;
            else if (pl)  m_st = 4;
        end else if (m_st == 4) begin
            if (am || ps) m_st = 5;
            else if (pl)  m_st = 3;
        end else if (m_st == 2) begin
            if (pr)             m_st = 1;
            else if (ps && !am) m_st = 3;
        end else begin
            if (pr)               m_st = 1;
            else if (ps && !am)   m_st = 4;
            else if (!ps && pl)   m_st = 2;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st   = (m_st == 1) ? 4'd1 : (m_st == 2 || m_st == 5) ? 4'd2 :
                 (m_st == 3 || m_st == 4) ? 4'd3 : 4'd0;
        e.clr  = (m_st == 1);
        e.hold = (m_st == 4 || m_st == 5);
        e.run  = (m_st == 3 || m_st == 4);
        return e;
    endfunction

    // Drive one cycle, queue the prediction, then compare after the edge.
    task automatic cyc(input logic rn, input logic ss, input logic lp,
                       input logic rs, input logic am);
        exp_t e;
        rst_n = rn; btn_startstop = ss; btn_lap = lp; btn_reset = rs; at_max = am;
        model_step(rn, ss, lp, rs, am);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (clear) clear_cycles++;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            chk("state", {4'd0, state}, {4'd0, e.st});
            chk("clear", {7'd0, clear}, {7'd0, e.clr});
            chk("display_hold", {7'd0, display_hold}, {7'd0, e.hold});
            chk("running", {7'd0, running}, {7'd0, e.run});
        end
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    // Press (one cycle high) then release.
    task automatic press(input logic ss, input logic lp, input logic rs, input logic am);
        cyc(1, ss, lp, rs, am);
    endtask

    task automatic rel(input logic am);
        cyc(1, 0, 0, 0, am);
    endtask

    initial begin
        n_pass = 0; n_tot = 0; clear_cycles = 0;
        m_st = 0; m_prev = 3'b111;
        rst_n = 0; btn_startstop = 0; btn_lap = 0; btn_reset = 0; at_max = 0;

        // Buttons held through reset produce no press.
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        chk("rst_state", {4'd0, state}, 8'd0);
        chk("rst_outs", {5'd0, clear, display_hold, running}, 8'd0);
        cyc(1, 1, 1, 1, 0);
        chk("held_idle", {4'd0, state}, 8'd0);
        rel(0);
        press(1, 0, 0, 0);
        chk("start_latency", {3'd0, running, state}, {3'd0, 1'b1, 4'd3});
        rel(0);

        // 0,3,2,1,0 with a one-cycle clear.
        do_reset();
        chk("seq0", {4'd0, state}, 8'd0);
        press(1, 0, 0, 0); chk("seq3", {4'd0, state}, 8'd3); rel(0);
        press(1, 0, 0, 0); chk("seq2", {4'd0, state}, 8'd2); rel(0);
        clear_cycles = 0;
        press(0, 0, 1, 0); chk("seq1", {3'd0, clear, state}, {3'd0, 1'b1, 4'd1});
        rel(0);            chk("seq0b", {3'd0, clear, state}, 8'd0);
        rel(0);
        chk("clear_width", clear_cycles[7:0], 8'd1);

        // Lap freeze while running across 100 cycles.
        press(1, 0, 0, 0); rel(0);
        press(0, 1, 0, 0);
        chk("lap_hold_up", {2'd0, display_hold, running, state}, {2'd0, 2'b11, 4'd3});
        for (int i = 0; i < 100; i++) rel(0);
        chk("lap_mid", {2'd0, display_hold, running, state}, {2'd0, 2'b11, 4'd3});
        press(0, 1, 0, 0);
        chk("lap_hold_dn", {2'd0, display_hold, running, state}, {2'd0, 2'b01, 4'd3});
        rel(0);

        // RUN, lap, startstop, lap.
        press(0, 1, 0, 0); rel(0);
        chk("laprun", {3'd0, display_hold, state}, {3'd0, 1'b1, 4'd3});
        press(1, 0, 0, 0); rel(0);
        chk("lapstop", {3'd0, display_hold, state}, {3'd0, 1'b1, 4'd2});
        press(0, 1, 0, 0); rel(0);
        chk("stopped", {3'd0, display_hold, state}, {3'd0, 1'b0, 4'd2});

        // Triple press while STOPPED: clear then idle, nothing else acted on.
        press(1, 1, 1, 0);
        chk("triple_stop", {4'd0, state}, 8'd1);
        for (int i = 0; i < 4; i++) rel(0);
        chk("triple_idle", {5'd0, clear, display_hold, running}, 8'd0);
        // Triple press while RUN: stop, lap discarded.
        press(1, 0, 0, 0); rel(0);
        press(1, 1, 1, 0); rel(0);
        chk("triple_run", {3'd0, display_hold, state}, {3'd0, 1'b0, 4'd2});

        // at_max auto-stop and start blocking.
        press(1, 0, 0, 0); rel(0);
        rel(1);
        chk("atmax_stop", {4'd0, state}, 8'd2);
        press(1, 0, 0, 1); rel(1);
        chk("atmax_block", {4'd0, state}, 8'd2);
        press(0, 0, 1, 1); chk("atmax_clr", {4'd0, state}, 8'd1);
        rel(1);            chk("atmax_idle", {4'd0, state}, 8'd0);
        rel(0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
        end

        if (exp_q.size() != 0) chk("queue_drain", exp_q.size() > 255 ? 8'd255 : 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/stopwatch_control_fsm.md
# stopwatch_control_fsm

Sequencing controller for the stopwatch. It turns the debounced start/stop, lap and reset buttons into the 4-bit `state` code consumed by the millisecond timer and the time counters, where code 4'd3 means "count". It also provides a lap display-freeze flag, a one-cycle counter-clear, and an automatic stop when the time counter reports its maximum value. It sits between the button debouncers and the timer/counter/display chain.

## Interface
Parameters: none (state encodings fixed below).

- `clk`  input  1  system clock (50 MHz)
- `rst_n`  input  1  reset: synchronous, active-low
- `btn_startstop`  input  1  debounced, synchronized level, active-high
- `btn_lap`  input  1  debounced, synchronized level, active-high
- `btn_reset`  input  1  debounced, synchronized level, active-high
- `at_max`  input  1  high while the time counter holds its maximum value
- `state`  output  4  timer/counter code: 4'd0 IDLE, 4'd1 CLEAR, 4'd2 STOPPED, 4'd3 RUNNING
- `clear`  output  1  high only during the single CLEAR cycle; zeroes the counters
- `display_hold`  output  1  high while the lap freeze is active
- `running`  output  1  high while the counters are counting (`state`==4'd3)

## Operation
- Press detect: each button is registered each cycle; press = btn & ~btn_prev. Prev registers reset to 1, so a button held through reset produces no press until it is released and pressed again.
- Priority within one cycle: reset > startstop > lap. Lower-priority presses in the same cycle are discarded, not queued.
- Internal FSM states, each shown as its output `state` / `display_hold`:
  - IDLE: 0 / 0
  - CLEAR: 1 / 0
  - STOPPED: 2 / 0
  - RUN: 3 / 0
  - LAP_RUN: 3 / 1
  - LAP_STOP: 2 / 1
- LAP_RUN must present 4'd3, because the timer counts only on 4'd3.
- Transitions:
  - IDLE: startstop -> RUN. Lap and reset are ignored.
  - CLEAR: -> IDLE unconditionally after one cycle.
  - RUN:
    - at_max -> STOPPED. This has the highest priority in the running states, except over reset, which is ignored here anyway.
    - startstop -> STOPPED.
    - lap -> LAP_RUN.
    - reset ignored.
  - LAP_RUN: at_max or startstop -> LAP_STOP. lap -> RUN. reset ignored.
  - STOPPED:
    - reset -> CLEAR.
    - startstop -> RUN only if at_max is low; otherwise stay.
    - lap ignored.
  - LAP_STOP:
    - reset -> CLEAR.
    - lap -> STOPPED (releases the freeze).
    - startstop -> LAP_RUN only if at_max is low.
  - Any unused internal encoding -> IDLE on the next edge.
- Output decode: `clear` = (CLEAR). `display_hold` = (LAP_RUN | LAP_STOP). `running` = (RUN | LAP_RUN). All outputs are decoded from the state register only, never from the inputs, so they are glitch-free.

## Timing
- Reset (`rst_n` low at an edge):
  - FSM -> IDLE.
  - `state`=4'd0, `clear`=0, `display_hold`=0, `running`=0.
  - btn_prev = 3'b111.
  - Reset mid-RUN or mid-LAP returns to IDLE without a CLEAR pulse. The counters are expected to use the same `rst_n`.
- Latency: a button first sampled high at edge k (prev low) updates `state` at edge k. Outputs are visible in cycle k+1. No further pipeline.
- `clear` is exactly one cycle wide. It is followed by `state`=4'd0 on the next cycle.
- A button held high produces exactly one press. Re-arming requires at least one cycle sampled low.
- at_max is level-sensitive. A stop occurs at the first edge where it is sampled high in RUN or LAP_RUN. While at_max is high, start is blocked in STOPPED and LAP_STOP; only reset (via CLEAR) escapes.
- No combinational path from any input to any output.

## Test plan
- Reset with all buttons held high, then release and press startstop one cycle later -> IDLE (0) held through release; state=3 and running=1 at the edge the press is sampled.
- IDLE -> startstop -> startstop -> reset -> state sequence 0,3,2,1,0. `clear` is high for exactly one cycle.
- RUN, lap, wait 100 cycles, lap -> display_hold rises at the first lap and falls at the second; state stays 3 and running stays 1 throughout.
- RUN, lap, startstop, lap -> states RUN(3/0), LAP_RUN(3/1), LAP_STOP(2/1), STOPPED(2/0).
- Startstop, lap and reset pressed in the same cycle while STOPPED -> CLEAR then IDLE; lap and startstop are not acted on afterwards. The same triple in RUN -> STOPPED (reset ignored, lap discarded).
- RUN with at_max asserted -> STOPPED on the next edge; startstop while at_max is high -> stays 2; reset -> 1, then 0.
